// File: rtl/note_step_scheduler_if.sv
// Request/acknowledge link between the step scheduler (master) and the shared
// tone-voice generator (slave).
interface note_step_scheduler_if;
  logic       req;
  logic [2:0] pitch;
  logic       ack;

  modport master (output req, output pitch, input ack);
  modport slave  (input req, input pitch, output ack);
endinterface

// File: rtl/note_step_scheduler.sv
// Column-sweeping step sequencer: each column's active rows are sent one at a time
// to a shared voice generator. Optional per-row enable via NOTE_STEP_SCHEDULER_ROWMASK_EN.
module note_step_scheduler #(
  parameter int unsigned STEP_CYCLES = 5000000,
  parameter int unsigned CNT_W       = 23
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic [63:0]                  iNote,
  input  logic                         iNote_valid,
  input  logic                         iStart,
  input  logic                         iStop,
`ifdef NOTE_STEP_SCHEDULER_ROWMASK_EN
  input  logic [7:0]                   iRow_mask,
`endif
  note_step_scheduler_if.master        voice,
  output logic [2:0]                   oStep,
  output logic                         oBar,
  output logic                         oOverrun,
  output logic                         oBusy
);

  typedef enum logic [1:0] {StIdle, StSnap, StIssue, StWait} state_e;

  state_e           state_q;
  logic [63:0]      shadow_q;
  logic [7:0]       pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       col_q;
  logic [2:0]       step_q;
  logic             bar_q;
  logic             overrun_q;
  logic             busy_q;
  logic             req_q;
  logic [2:0]       pitch_q;

  logic [7:0]       row_en;
  logic [7:0]       pend_snap;
  logic [7:0]       pend_left;
  logic             ack_fire;
  logic             expiry;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
`ifdef NOTE_STEP_SCHEDULER_ROWMASK_EN
    row_en = iRow_mask;
`else
    row_en = 8'hFF;
`endif
    // Grid bit for (row r, column c) lives at index {r, c}.
    for (int r = 0; r < 8; r++) begin
      pend_snap[r] = shadow_q[{3'(r), col_q}] & row_en[r];
    end
    ack_fire  = req_q & voice.ack;
    pend_left = pend_q;
    if (ack_fire) pend_left = pend_q & ~(8'b1 << pitch_q);
    expiry    = (cnt_q == CNT_W'(STEP_CYCLES - 1));
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      pend_q    <= '0;
      cnt_q     <= '0;
      col_q     <= '0;
      step_q    <= '0;
      bar_q     <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
      pitch_q   <= '0;
    end else begin
      bar_q <= 1'b0;
      if (iNote_valid) shadow_q <= iNote;

      if (iStop) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
        req_q   <= 1'b0;
        pend_q  <= '0;
        col_q   <= '0;
        step_q  <= '0;
        cnt_q   <= '0;
      end else if (iStart) begin
        // Start and restart share one path; an in-flight request is dropped.
        state_q   <= StSnap;
        busy_q    <= 1'b1;
        req_q     <= 1'b0;
        pend_q    <= '0;
        col_q     <= '0;
        cnt_q     <= '0;
        overrun_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
          end
          StSnap: begin
            step_q  <= col_q;
            pend_q  <= pend_snap;
            req_q   <= |pend_snap;
            pitch_q <= lowest_set(pend_snap);
            state_q <= (|pend_snap) ? StIssue : StWait;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
          StIssue, StWait: begin
            if (expiry) begin
              // An ack landing in the expiry cycle still counts as delivered.
              if (|pend_left) overrun_q <= 1'b1;
              cnt_q   <= '0;
              col_q   <= col_q + 3'd1;
              bar_q   <= (col_q == 3'd7);
              state_q <= StSnap;
              req_q   <= 1'b0;
              pend_q  <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (state_q == StIssue) begin
                if (ack_fire) begin
                  pend_q <= pend_left;
                  req_q  <= 1'b0;
                  if (pend_left == '0) state_q <= StWait;
                end else if (!req_q) begin
                  req_q   <= 1'b1;
                  pitch_q <= lowest_set(pend_q);
                end
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign voice.req   = req_q;
  assign voice.pitch = pitch_q;
  assign oStep       = step_q;
  assign oBar        = bar_q;
  assign oOverrun    = overrun_q;
  assign oBusy       = busy_q;

endmodule

// File: tb/tb_note_step_scheduler.sv
// Self-checking bench for note_step_scheduler with a 20-cycle step and a
// scoreboard of expected voice transfers.
module tb_note_step_scheduler;

  typedef struct {
    logic [2:0] pitch;
    logic [2:0] step;
    int         cyc;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] note;
  logic        note_valid;
  logic        start;
  logic        stop;
  logic [7:0]  row_mask;
  logic [2:0]  step;
  logic        bar;
  logic        overrun;
  logic        busy;

  note_step_scheduler_if vif ();

  note_step_scheduler #(
    .STEP_CYCLES(20),
    .CNT_W      (5)
  ) dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iNote      (note),
    .iNote_valid(note_valid),
    .iStart     (start),
    .iStop      (stop),
`ifdef NOTE_STEP_SCHEDULER_ROWMASK_EN
    .iRow_mask  (row_mask),
`endif
    .voice      (vif),
    .oStep      (step),
    .oBar       (bar),
    .oOverrun   (overrun),
    .oBusy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int    total = 0;
  int    bad   = 0;
  xfer_t got_q[$];
  xfer_t exp_q[$];
  int    rise_cyc_q[$];
  int    rise_step_q[$];
  int    bar_cnt;
  int    bar_cyc;
  bit    ack_en;
  int    ack_delay;
  int    req_age = 0;
  logic  req_prev = 1'b0;

  // Voice responder and monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    xfer_t x;
    if (vif.req) begin
      vif.ack = ack_en && (req_age >= ack_delay);
      req_age++;
    end else begin
      vif.ack = 1'b0;
      req_age = 0;
    end
    if (vif.req && vif.ack) begin
      x.pitch = vif.pitch;
      x.step  = step;
      x.cyc   = cyc;
      got_q.push_back(x);
    end
    if (vif.req && !req_prev) begin
      rise_cyc_q.push_back(cyc);
      rise_step_q.push_back(int'(step));
    end
    req_prev = vif.req;
    if (bar) begin
      bar_cnt++;
      bar_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_play();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_play();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic load_grid(input logic [63:0] g);
    note       = g;
    note_valid = 1'b1;
    tick();
    note_valid = 1'b0;
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    rise_cyc_q.delete();
    rise_step_q.delete();
    bar_cnt = 0;
    bar_cyc = -1;
  endtask

  task automatic push_exp(input logic [2:0] p, input logic [2:0] s);
    xfer_t x;
    x.pitch = p;
    x.step  = s;
    x.cyc   = 0;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    logic [4:0] outs;
    tick();
    tick();
    outs = {vif.req, bar, busy, overrun, |step};
    total++;
    if (outs !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b expected 00000", outs);
    end
    rst = 1'b0;
    tick();
    ack_en = 1'b0;
    clear_mon();
    load_grid(64'h0101010101010101 | (64'h1 << 25));
    start_play();
    repeat (21) tick();
    total++;
    if ({vif.req, step, overrun} !== {1'b1, 3'd1, 1'b1}) begin
      bad++;
      $display("FAIL reset_pre_issue: got req=%b step=%0d ovr=%b expected req=1 step=1 ovr=1",
               vif.req, step, overrun);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({vif.req, busy, overrun, step} !== 6'b0) begin
      bad++;
      $display("FAIL reset_async: got req=%b busy=%b ovr=%b step=%0d expected all 0",
               vif.req, busy, overrun, step);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    repeat (30) tick();
    total++;
    if (rise_cyc_q.size() !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_quiet: got reqs=%0d busy=%b expected reqs=0 busy=0",
               rise_cyc_q.size(), busy);
    end
  endtask

  task automatic test_sweep();
    int    k;
    xfer_t e;
    xfer_t g;
    clear_mon();
    load_grid(64'h0000_0000_0000_00FF);
    ack_en    = 1'b1;
    ack_delay = 2;
    for (int i = 0; i < 9; i++) push_exp(3'd0, 3'(i % 8));
    start_play();
    k = cyc;
    repeat (170) tick();
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL sweep_overrun: got %b expected 0", overrun);
    end
    stop_play();
    total++;
    if ({busy, step} !== 4'b0) begin
      bad++;
      $display("FAIL sweep_stop: got busy=%b step=%0d expected 0 0", busy, step);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++;
        $display("FAIL sweep_xfer: got none expected pitch=%0d step=%0d", e.pitch, e.step);
      end else begin
        g = got_q.pop_front();
        if ({g.pitch, g.step} !== {e.pitch, e.step}) begin
          bad++;
          $display("FAIL sweep_xfer: got pitch=%0d step=%0d expected pitch=%0d step=%0d",
                   g.pitch, g.step, e.pitch, e.step);
        end
      end
    end
    total++;
    if (got_q.size() !== 0 || rise_cyc_q.size() !== 9) begin
      bad++;
      $display("FAIL sweep_count: got extra=%0d reqs=%0d expected extra=0 reqs=9",
               got_q.size(), rise_cyc_q.size());
    end
    for (int i = 0; i < rise_cyc_q.size(); i++) begin
      total++;
      if (rise_cyc_q[i] !== k + 1 + 20 * i || rise_step_q[i] !== i % 8) begin
        bad++;
        $display("FAIL sweep_step%0d: got cyc=%0d step=%0d expected cyc=%0d step=%0d", i,
                 rise_cyc_q[i] - k, rise_step_q[i], 1 + 20 * i, i % 8);
      end
    end
    total++;
    if (bar_cnt !== 1 || bar_cyc !== k + 160) begin
      bad++;
      $display("FAIL sweep_bar: got cnt=%0d at=%0d expected cnt=1 at=160", bar_cnt,
               bar_cyc - k);
    end
  endtask

  task automatic test_chord();
    int    k;
    int    prev;
    xfer_t e;
    xfer_t g;
    clear_mon();
    load_grid((64'h1 << 51) | (64'h1 << 19) | (64'h1 << 43));
    ack_en    = 1'b1;
    ack_delay = 0;
    push_exp(3'd2, 3'd3);
    push_exp(3'd5, 3'd3);
    push_exp(3'd6, 3'd3);
    start_play();
    k    = cyc;
    prev = k + 59;
    repeat (80) tick();
    stop_play();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++;
        $display("FAIL chord_xfer: got none expected pitch=%0d", e.pitch);
      end else begin
        g = got_q.pop_front();
        if ({g.pitch, g.step} !== {e.pitch, e.step} || g.cyc !== prev + 2) begin
          bad++;
          $display("FAIL chord_xfer: got pitch=%0d step=%0d at=%0d expected pitch=%0d step=%0d at=%0d",
                   g.pitch, g.step, g.cyc - k, e.pitch, e.step, prev + 2 - k);
        end
        prev = g.cyc;
      end
    end
    total++;
    if (got_q.size() !== 0) begin
      bad++;
      $display("FAIL chord_extra: got %0d expected 0", got_q.size());
    end
  endtask

  task automatic test_overrun();
    int held;
    clear_mon();
    load_grid(64'h0101010101010101);
    ack_en = 1'b0;
    start_play();
    held = 0;
    for (int i = 1; i < 20; i++) begin
      tick();
      if (vif.req === 1'b1 && vif.pitch === 3'd0) held++;
    end
    total++;
    if (held !== 19) begin
      bad++;
      $display("FAIL overrun_hold: got %0d cycles expected 19", held);
    end
    tick();
    total++;
    if ({overrun, vif.req, bar} !== 3'b100) begin
      bad++;
      $display("FAIL overrun_expiry: got ovr=%b req=%b bar=%b expected 1 0 0", overrun,
               vif.req, bar);
    end
    tick();
    total++;
    if (step !== 3'd1 || vif.req !== 1'b0) begin
      bad++;
      $display("FAIL overrun_next: got step=%0d req=%b expected step=1 req=0", step, vif.req);
    end
    stop_play();
    total++;
    if ({overrun, busy} !== 2'b10) begin
      bad++;
      $display("FAIL overrun_retain: got ovr=%b busy=%b expected 1 0", overrun, busy);
    end
  endtask

  task automatic test_snapshot();
    xfer_t e;
    xfer_t g;
    clear_mon();
    load_grid((64'h1 << 10) | (64'h1 << 11));
    ack_en    = 1'b1;
    ack_delay = 0;
    push_exp(3'd1, 3'd2);
    start_play();
    repeat (45) tick();
    load_grid((64'h1 << 34) | (64'h1 << 59));
    push_exp(3'd7, 3'd3);
    repeat (30) tick();
    stop_play();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++;
        $display("FAIL snap_xfer: got none expected pitch=%0d step=%0d", e.pitch, e.step);
      end else begin
        g = got_q.pop_front();
        if ({g.pitch, g.step} !== {e.pitch, e.step}) begin
          bad++;
          $display("FAIL snap_xfer: got pitch=%0d step=%0d expected pitch=%0d step=%0d",
                   g.pitch, g.step, e.pitch, e.step);
        end
      end
    end
    total++;
    if (got_q.size() !== 0) begin
      bad++;
      $display("FAIL snap_extra: got %0d expected 0", got_q.size());
    end
  endtask

  task automatic test_start_stop();
    clear_mon();
    load_grid(64'h0101010101010101);
    ack_en = 1'b0;
    start_play();
    repeat (25) tick();
    total++;
    if ({step, overrun} !== {3'd1, 1'b1}) begin
      bad++;
      $display("FAIL ss_pre: got step=%0d ovr=%b expected 1 1", step, overrun);
    end
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    total++;
    if ({busy, step, vif.req, overrun} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL ss_collide: got busy=%b step=%0d req=%b ovr=%b expected 0 0 0 1", busy,
               step, vif.req, overrun);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ss_idle: got busy=%b expected 0", busy);
    end
    start_play();
    total++;
    if ({overrun, busy} !== 2'b01) begin
      bad++;
      $display("FAIL ss_restart: got ovr=%b busy=%b expected 0 1", overrun, busy);
    end
    tick();
    total++;
    if ({step, vif.req, vif.pitch} !== {3'd0, 1'b1, 3'd0}) begin
      bad++;
      $display("FAIL ss_col0: got step=%0d req=%b pitch=%0d expected 0 1 0", step, vif.req,
               vif.pitch);
    end
    stop_play();
  endtask

  initial begin
    rst        = 1'b1;
    note       = '0;
    note_valid = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    row_mask   = 8'hFF;
    ack_en     = 1'b0;
    ack_delay  = 0;
    bar_cnt    = 0;
    bar_cyc    = -1;
    test_reset();
    test_sweep();
    test_chord();
    test_overrun();
    test_snapshot();
    test_start_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
